// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// the set of legal byte-lane strobe patterns and the wait-state limit.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WAIT_CYCLES_MAX = 15;

  localparam int N_LEGAL_WEN = 8;
  localparam logic [3:0] LEGAL_WEN [N_LEGAL_WEN] = '{
    4'b0000, 4'b0001, 4'b0010, 4'b0100,
    4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic wen_is_legal(input logic [3:0] wen);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL_WEN; i++) begin
      if (wen == LEGAL_WEN[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_bank_ram.sv
// Word memory built from four byte-wide banks with per-lane write enables and
// a registered, write-first read port (reads return the post-write word).
module dmem_bank_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en_i && we_i[l]) mem[addr_i] <= wdata_i[8*l +: 8];
    end

    // Read register is cleared on reset and on rejected accesses.
    always_ff @(posedge clk) begin
      if (clr_i) begin
        rd_q <= 8'd0;
      end else if (en_i) begin
        rd_q <= we_i[l] ? wdata_i[8*l +: 8] : mem[addr_i];
      end
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one access, waits a fixed
// number of cycles, commits the store / captures the read, pulses a response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        hold_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_CYCLES_MAX || DEPTH_WORDS < 4 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_param
    $error("dmem_responder: illegal DEPTH_WORDS or WAIT_CYCLES");
  end

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          ready_q;
  logic          hold_q;
  logic          resp_valid_q;
  logic          resp_err_q;

  logic [3:0]    wen_q;
  logic [AW-1:0] widx_q;
  logic [31:0]   wdata_q;
  logic          err_q;

  logic          accept;
  logic          req_err;
  logic          go_resp;
  logic          use_live;
  logic [3:0]    ram_wen;
  logic          ram_err;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [1:0]    unused_addr_bits;

  assign unused_addr_bits = req_addr[1:0];

  assign accept  = req_valid & ready_q;
  assign req_err = ~wen_is_legal(req_wen) | (|req_addr[31:AW+2]);

  // The commit edge is the one entering RESP; with no wait states that is the
  // accept edge itself, so the RAM is fed straight from the request port.
  assign go_resp = ~rst & (((state_q == ST_IDLE) & accept & (WAIT_CYCLES == 0)) |
                           ((state_q == ST_WAIT) & (cnt_q == 4'd0)));
  assign use_live  = (state_q == ST_IDLE);
  assign ram_wen   = use_live ? req_wen : wen_q;
  assign ram_err   = use_live ? req_err : err_q;
  assign ram_idx   = use_live ? req_addr[AW+1:2] : widx_q;
  assign ram_wdata = use_live ? req_wdata : wdata_q;

  dmem_bank_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .en_i   (go_resp),
    .clr_i  (rst | (go_resp & ram_err)),
    .we_i   (ram_wen & {4{~ram_err}}),
    .addr_i (ram_idx),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      widx_q  <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
      err_q   <= req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      ready_q      <= 1'b1;
      hold_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            hold_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= req_err;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
          hold_q       <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign hold_o     = hold_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = ram_rdata;

endmodule
